dsp: RTL and testbench
======================

Name: dsp

Overview:
- Pipelined signed multiply-accumulate slice, modelled on an FPGA DSP48-style primitive.
- Each enabled cycle it multiplies OP1 by OP2 and either loads the product into the output accumulator or adds it to the accumulator.
- Used as the arithmetic core for dot-product and FIR-style datapaths.

Parameters:
- WIDTH_OP1, 18, width of signed operand OP1 (two's complement).
- WIDTH_OP2, 25, width of signed operand OP2 (two's complement).
- WIDTH_OUT, 48, width of signed accumulator/output. Legal only when WIDTH_OUT >= WIDTH_OP1+WIDTH_OP2.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RSTN  input  1  reset, asynchronous and active-high (name kept per codebase convention; the polarity is high).
- EN  input  1  clock enable for every pipeline stage.
- ACC_EN  input  1  1 = accumulate the product into P; 0 = load the product into P.
- OP1  input  WIDTH_OP1  signed multiplicand.
- OP2  input  WIDTH_OP2  signed multiplier.
- OUT  output  WIDTH_OUT  signed accumulator value (registered).

Behaviour:
- Three register stages, all clocked on the CLK rising edge and gated by EN.
  - Stage 1: A <= OP1, B <= OP2, ACC1 <= ACC_EN.
  - Stage 2: M <= A*B as a signed full-width product (WIDTH_OP1+WIDTH_OP2 bits), ACC2 <= ACC1.
  - Stage 3: P <= ACC2 ? P + sext(M) : sext(M).
- OUT = P, driven directly from the register with no combinational path from any input.
- Latency: operands and ACC_EN presented before edge k affect OUT after edge k+2, i.e. the third rising edge including k.
- Throughput is one operation per cycle while EN=1.
- ACC_EN travels down the pipeline with its operands. A change of ACC_EN therefore applies exactly to the operand pair sampled on the same edge.
- EN=0: every register (A, B, M, ACC1, ACC2, P) holds, and OUT is stable. Pipeline contents resume unchanged when EN returns to 1.
- Arithmetic:
  - The product is sign-extended to WIDTH_OUT.
  - Accumulation wraps modulo 2^WIDTH_OUT; there is no saturation and no overflow flag.
  - The extreme product (-2^17)*(-2^24) = +2^41 is representable.
- Reset: RSTN=1 clears A, B, M, ACC1, ACC2 and P to 0 immediately, without waiting for a clock edge, so OUT=0 during reset.
  - Reset overrides EN.
  - Operands in flight at reset are discarded.
  - The first rising edge with RSTN=0 performs a normal update.
- Accumulation after reset starts from P=0. An operand pair with ACC_EN=1 that follows reset therefore yields its own product.
- Zero operands with ACC_EN=1 leave P unchanged, because they add 0.

Decomposition:
- Shared package dsp_pkg holds the default constants WIDTH_OP1=18, WIDTH_OP2=25 and WIDTH_OUT=48, plus a product-width constant (43).
- One natural sub-module, dsp_mult_pipe. It holds stages 1–2 (operand registers and product register, with ACC_EN delay) and takes EN and reset.
- The top level instantiates dsp_mult_pipe and implements the stage-3 accumulator.

Test Plan:
- Reset: assert RSTN with random operands and EN=1 -> OUT=0 immediately and throughout reset. After release with OP1=OP2=0 -> OUT stays 0.
- Load mode: ACC_EN=0, apply OP1=3, OP2=-5 for one cycle, then zeros -> OUT=-15 after the 3rd edge, then 0 on the next edge.
- Accumulate: after reset, ACC_EN=1, pairs (2,3), (4,5), (-1,7), then (0,0) held -> OUT steps 6, 26, 19 on consecutive edges starting 3 edges after the first pair, then holds 19. Repeat with 11 random pairs in [-31,31] and check OUT equals the running sum of products 4 edges after the last pair.
- Mode switch alignment: pairs (10,10) with ACC_EN=1, then (1,1) with ACC_EN=0, then (2,2) with ACC_EN=1, starting from P=0 -> OUT sequence 100, 1, 5.
- Enable hold: during accumulation drop EN for 3 cycles while changing OP1/OP2 -> OUT frozen. After EN=1 the sum continues exactly as if the stalled cycles never happened.
- Wrap and async reset: OP1=-131072, OP2=-16777216, ACC_EN=1 for 128 cycles -> OUT=0 (2^48 wrap); after 127 cycles OUT=2^48-2^41 (negative). Then assert RSTN mid-stream between edges -> OUT=0 at once and no residual product appears after release.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared constants for the dsp multiply-accumulate slice.
package dsp_pkg;

    // Default operand and accumulator widths (DSP48-style slice).
    localparam int DEF_WIDTH_OP1  = 18;
    localparam int DEF_WIDTH_OP2  = 25;
    localparam int DEF_WIDTH_OUT  = 48;

    // Full-width signed product of the two default operands.
    localparam int DEF_WIDTH_PROD = DEF_WIDTH_OP1 + DEF_WIDTH_OP2;

endpackage

// File: rtl/dsp_mult_pipe.sv
// Stages 1-2 of the MAC slice: operand registers, then a registered full-width
// signed product. ACC_EN rides alongside so it stays paired with its operands.
//
// EN is a global stall: when low every register holds its contents, and when
// it returns high the pipeline resumes exactly where it stopped. There is no
// valid/ready handshake; each enabled edge accepts one operand pair.
module dsp_mult_pipe
    import dsp_pkg::*;
#(
    parameter  int WIDTH_OP1  = DEF_WIDTH_OP1,
    parameter  int WIDTH_OP2  = DEF_WIDTH_OP2,
    localparam int WIDTH_PROD = WIDTH_OP1 + WIDTH_OP2
) (
    input  logic                         CLK,
    input  logic                         RSTN,
    input  logic                         EN,
    input  logic                         ACC_EN,
    input  logic signed [WIDTH_OP1-1:0]  OP1,
    input  logic signed [WIDTH_OP2-1:0]  OP2,
    output logic signed [WIDTH_PROD-1:0] prod,
    output logic                         acc
);

    logic signed [WIDTH_OP1-1:0]  a;
    logic signed [WIDTH_OP2-1:0]  b;
    logic                         acc1;
    logic signed [WIDTH_PROD-1:0] m;
    logic                         acc2;

    // Stage 1: capture the operand pair and its accumulate flag.
    always_ff @(posedge CLK or posedge RSTN) begin
        if (RSTN) begin
            a    <= '0;
            b    <= '0;
            acc1 <= 1'b0;
        end else if (EN) begin
            a    <= OP1;
            b    <= OP2;
            acc1 <= ACC_EN;
        end
    end

    // Stage 2: full-width signed product; both operands are sign-extended
    // before the multiply so the extreme case (-2^17)*(-2^24) stays positive.
    always_ff @(posedge CLK or posedge RSTN) begin
        if (RSTN) begin
            m    <= '0;
            acc2 <= 1'b0;
        end else if (EN) begin
            m    <= WIDTH_PROD'(a) * WIDTH_PROD'(b);
            acc2 <= acc1;
        end
    end

    assign prod = m;
    assign acc  = acc2;

endmodule

// File: rtl/dsp.sv
// Pipelined signed multiply-accumulate slice. Three enabled stages:
// operands -> product -> accumulator P. OUT comes straight from P.
// WIDTH_OUT must be at least WIDTH_OP1 + WIDTH_OP2.
module dsp
    import dsp_pkg::*;
#(
    parameter int WIDTH_OP1 = DEF_WIDTH_OP1,
    parameter int WIDTH_OP2 = DEF_WIDTH_OP2,
    parameter int WIDTH_OUT = DEF_WIDTH_OUT
) (
    input  logic                        CLK,
    input  logic                        RSTN,
    input  logic                        EN,
    input  logic                        ACC_EN,
    input  logic signed [WIDTH_OP1-1:0] OP1,
    input  logic signed [WIDTH_OP2-1:0] OP2,
    output logic signed [WIDTH_OUT-1:0] OUT
);

    localparam int WIDTH_PROD = WIDTH_OP1 + WIDTH_OP2;

    logic signed [WIDTH_PROD-1:0] prod;
    logic                         acc;
    logic signed [WIDTH_OUT-1:0]  prod_ext;
    logic signed [WIDTH_OUT-1:0]  p;

    dsp_mult_pipe #(
        .WIDTH_OP1 (WIDTH_OP1),
        .WIDTH_OP2 (WIDTH_OP2)
    ) u_mult_pipe (
        .CLK    (CLK),
        .RSTN   (RSTN),
        .EN     (EN),
        .ACC_EN (ACC_EN),
        .OP1    (OP1),
        .OP2    (OP2),
        .prod   (prod),
        .acc    (acc)
    );

    // Signed size cast sign-extends the product to the accumulator width.
    assign prod_ext = WIDTH_OUT'(prod);

    // Stage 3: load or accumulate; the sum wraps modulo 2^WIDTH_OUT.
    always_ff @(posedge CLK or posedge RSTN) begin
        if (RSTN) begin
            p <= '0;
        end else if (EN) begin
            p <= acc ? (p + prod_ext) : prod_ext;
        end
    end

    assign OUT = p;

endmodule

// File: tb/tb_dsp.sv
// Self-checking bench for the dsp MAC slice: a queue-based behavioural model
// plus hand-computed expectations for the directed scenarios.
module tb_dsp;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        EN;
    logic        ACC_EN;
    logic [17:0] OP1;
    logic [24:0] OP2;
    logic [47:0] OUT;

    int total = 0;
    int bad   = 0;

    dsp dut (
        .CLK    (CLK),
        .RSTN   (RSTN),
        .EN     (EN),
        .ACC_EN (ACC_EN),
        .OP1    (OP1),
        .OP2    (OP2),
        .OUT    (OUT)
    );

    // Clock: 10 ns period.
    always #5 CLK = ~CLK;

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, required finish before 1 ms");
        $fatal(1);
    end

    // ---------------- behavioural model ----------------
    // Each accepted operation is {accumulate flag, sign-extended product}.
    // An operation accepted on an enabled edge reaches P two enabled edges
    // later, so the queue is primed with two load-zero entries at reset.
    typedef struct packed {
        logic        acc;
        logic [47:0] prod;
    } op_t;

    op_t         pq[$];
    logic [47:0] p_m = '0;

    function automatic logic [47:0] prod48(input logic [17:0] a, input logic [24:0] b);
        longint pa;
        longint pb;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        return 48'(pa * pb);
    endfunction

    always @(posedge CLK or posedge RSTN) begin
        op_t o;
        op_t n;
        if (RSTN) begin
            pq.delete();
            pq.push_back('0);
            pq.push_back('0);
            p_m = '0;
        end else if (EN) begin
            n.acc  = ACC_EN;
            n.prod = prod48(OP1, OP2);
            pq.push_back(n);
            o   = pq.pop_front();
            p_m = o.acc ? (p_m + o.prod) : o.prod;
        end
    end

    // ---------------- checking and driver tasks ----------------
    task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%012h) required %0d (0x%012h)",
                     name, $signed(got), got, $signed(exp), exp);
        end
    endtask

    // Drive one cycle of inputs, let one rising edge pass, compare at the falling edge.
    task automatic step(input bit en, input bit acc, input int a, input int b);
        EN     = en;
        ACC_EN = acc;
        OP1    = 18'(a);
        OP2    = 25'(b);
        @(posedge CLK);
        @(negedge CLK);
        check("model", OUT, p_m);
    endtask

    // Assert reset between edges with junk operands and EN=1, release at a falling edge.
    task automatic reset_pulse();
        #2;
        RSTN   = 1'b1;
        EN     = 1'b1;
        ACC_EN = 1'b1;
        OP1    = 18'($urandom);
        OP2    = 25'($urandom);
        #1;
        check("reset_immediate", OUT, 48'd0);
        @(posedge CLK);
        @(negedge CLK);
        check("reset_held", OUT, 48'd0);
        RSTN   = 1'b0;
        ACC_EN = 1'b0;
        OP1    = '0;
        OP2    = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int     pa[6];
        int     pb[6];
        int     exp_acc[6];
        longint sum_lit;
        longint prods[5];
        int     a;
        int     b;

        // Reset with random operands: OUT is zero at once and throughout.
        RSTN   = 1'b1;
        EN     = 1'b1;
        ACC_EN = 1'b1;
        OP1    = 18'($urandom);
        OP2    = 25'($urandom);
        #1;
        check("reset_t0", OUT, 48'd0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, int'($urandom), int'($urandom));
            check("reset_during", OUT, 48'd0);
        end
        RSTN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0);
            check("reset_release_zero", OUT, 48'd0);
        end

        // Load mode: 3 * -5 appears after the third edge, then reloads zero.
        step(1, 0, 3, -5);
        check("load_e1", OUT, 48'd0);
        step(1, 0, 0, 0);
        check("load_e2", OUT, 48'd0);
        step(1, 0, 0, 0);
        check("load_e3", OUT, 48'(-15));
        step(1, 0, 0, 0);
        check("load_e4", OUT, 48'd0);

        // Accumulate from reset: 6, 26, 19 then hold.
        reset_pulse();
        pa      = '{2, 4, -1, 0, 0, 0};
        pb      = '{3, 5, 7, 0, 0, 0};
        exp_acc = '{0, 0, 6, 26, 19, 19};
        for (int i = 0; i < 6; i++) begin
            step(1, 1, pa[i], pb[i]);
            check("acc_seq", OUT, 48'(exp_acc[i]));
        end
        sum_lit = 19;
        for (int i = 0; i < 11; i++) begin
            a = int'($urandom_range(0, 62)) - 31;
            b = int'($urandom_range(0, 62)) - 31;
            step(1, 1, a, b);
            sum_lit += longint'(a) * longint'(b);
        end
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
        check("acc_random_sum", OUT, 48'(sum_lit));

        // Mode switch alignment: 100, 1, 5.
        reset_pulse();
        step(1, 1, 10, 10);
        step(1, 0, 1, 1);
        step(1, 1, 2, 2);
        check("mode_e3", OUT, 48'd100);
        step(1, 1, 0, 0);
        check("mode_e4", OUT, 48'd1);
        step(1, 1, 0, 0);
        check("mode_e5", OUT, 48'd5);

        // Enable hold: stall 3 cycles with changing operands mid-accumulation.
        sum_lit = 5;
        for (int i = 0; i < 5; i++) begin
            a = int'($urandom_range(0, 200)) - 100;
            b = int'($urandom_range(0, 200)) - 100;
            prods[i] = longint'(a) * longint'(b);
            step(1, 1, a, b);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, int'($urandom_range(0, 1)), int'($urandom), int'($urandom));
            check("stall_frozen", OUT, 48'(sum_lit + prods[0] + prods[1] + prods[2]));
        end
        step(1, 1, 0, 0);
        check("stall_resume1", OUT, 48'(sum_lit + prods[0] + prods[1] + prods[2] + prods[3]));
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        check("stall_resume_sum",
              OUT, 48'(sum_lit + prods[0] + prods[1] + prods[2] + prods[3] + prods[4]));

        // Wrap: 128 extreme products of +2^41 sum to 2^48 == 0.
        reset_pulse();
        for (int i = 0; i < 128; i++) step(1, 1, -131072, -16777216);
        step(1, 1, 0, 0);
        check("wrap_127", OUT, 48'hFE00_0000_0000);
        check("wrap_127_negative", {47'd0, OUT[47]}, 48'd1);
        step(1, 1, 0, 0);
        check("wrap_128", OUT, 48'd0);

        // Async reset mid-stream: nothing in flight survives.
        for (int i = 0; i < 4; i++) step(1, 1, -131072, -16777216);
        check("midstream_nonzero", OUT, 48'h0400_0000_0000);
        reset_pulse();
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 0);
            check("no_residual", OUT, 48'd0);
        end

        // Random traffic: random enable, mode, full-range operands, rare resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                reset_pulse();
            end else begin
                step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                     int'($urandom), int'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
